// File: rtl/exec_hazard_ctrl_if.sv
// Hazard-control bundle between the Ex-stage pipeline datapath and exec_hazard_ctrl.
// master: pipeline side (drives ID/Ex fields, consumes selects and stall/flush).
// slave : hazard controller.
interface exec_hazard_ctrl_if;
    logic [4:0] Rs_Id;
    logic [4:0] Rt_Id;
    logic       RsUse_Id;
    logic       RtUse_Id;
    logic       ALUSrc_Id;
    logic [4:0] Reg_Target_Ex;
    logic       RegWr_Ex;
    logic       MemToReg_Ex;
    logic       Branch_Taken_Ex;
    logic       Jump_Ex;
    logic [1:0] ALUSrcA_ByPassing;
    logic [1:0] ALUSrcB_ByPassing;
    logic [1:0] busBSrc_ByPassing;
    logic       Stall_PC;
    logic       Stall_IfId;
    logic       Flush_IfId;
    logic       Flush_IdEx;

    modport master (
        output Rs_Id, Rt_Id, RsUse_Id, RtUse_Id, ALUSrc_Id,
        output Reg_Target_Ex, RegWr_Ex, MemToReg_Ex, Branch_Taken_Ex, Jump_Ex,
        input  ALUSrcA_ByPassing, ALUSrcB_ByPassing, busBSrc_ByPassing,
        input  Stall_PC, Stall_IfId, Flush_IfId, Flush_IdEx
    );

    modport slave (
        input  Rs_Id, Rt_Id, RsUse_Id, RtUse_Id, ALUSrc_Id,
        input  Reg_Target_Ex, RegWr_Ex, MemToReg_Ex, Branch_Taken_Ex, Jump_Ex,
        output ALUSrcA_ByPassing, ALUSrcB_ByPassing, busBSrc_ByPassing,
        output Stall_PC, Stall_IfId, Flush_IfId, Flush_IdEx
    );
endinterface

// File: rtl/exec_hazard_ctrl.sv
// Ex-stage hazard/bypass controller for the 5-stage MIPS pipeline.
// Shadows the source regs of the Ex instruction and the destinations held in
// Ex/Mem and Mem/Wr, producing ALU A/B and store-data bypass selects. Detects
// load-use (RegWr & MemToReg & dst!=0 & ID reads dst) for a one-cycle bubble and
// flushes IF/ID + ID/Ex for BR_PENALTY cycles on a taken branch/jump in Ex.
// Optional macro HAZ_PERF_CNT_EN adds saturating Stall_Cnt/Flush_Cnt counters.
module exec_hazard_ctrl #(
    parameter int BR_PENALTY = 1
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    exec_hazard_ctrl_if.slave    hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]     Stall_Cnt,
    output logic [CNT_W-1:0]     Flush_Cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_BRFLUSH = 2'd2
    } state_t;

    localparam bit         HAS_BRFLUSH = (BR_PENALTY > 1);
    localparam logic [1:0] CNT_INIT    = 2'(BR_PENALTY - 1);

    // Bypass select for one source: Ex/Mem (not a load) beats Mem/Wr; $0 never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       src_use,
        input logic [4:0] em_dst,
        input logic       em_wr,
        input logic       em_ld,
        input logic [4:0] mw_dst,
        input logic       mw_wr
    );
        logic [1:0] sel;
        if (em_wr && (em_dst != 5'd0) && (em_dst == src) && src_use && !em_ld) begin
            sel = 2'b01;
        end else if (mw_wr && (mw_dst != 5'd0) && (mw_dst == src) && src_use) begin
            sel = 2'b00;
        end else begin
            sel = 2'b11;
        end
        return sel;
    endfunction

    state_t     state_r, state_nxt_s;
    logic [1:0] cnt_r, cnt_nxt_s;

    logic [4:0] ex_rs_r, ex_rt_r;
    logic       ex_rsuse_r, ex_rtuse_r, ex_alusrc_r, ex_valid_r;
    logic [4:0] em_dst_r;
    logic       em_wr_r, em_ld_r;
    logic [4:0] mw_dst_r;
    logic       mw_wr_r;

    logic       taken_s, load_use_s;
    logic       stall_s, flush_ifid_s, flush_idex_s;
    logic [1:0] rs_fwd_s, rt_fwd_s, srcb_s;

    // A bubble in Ex (valid=0) cannot redirect or stall the pipeline.
    assign taken_s    = ex_valid_r & (hz.Branch_Taken_Ex | hz.Jump_Ex);
    assign load_use_s = ex_valid_r & hz.RegWr_Ex & hz.MemToReg_Ex & (hz.Reg_Target_Ex != 5'd0) &
                        ((hz.RsUse_Id & (hz.Rs_Id == hz.Reg_Target_Ex)) |
                         (hz.RtUse_Id & (hz.Rt_Id == hz.Reg_Target_Ex)));

    // FSM state and branch-flush counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
            cnt_r   <= 2'd0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // FSM next-state: a taken branch outranks load-use since the ID instr is squashed.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (taken_s) begin
                    if (HAS_BRFLUSH) begin
                        state_nxt_s = ST_BRFLUSH;
                        cnt_nxt_s   = CNT_INIT;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end else if (load_use_s) begin
                    state_nxt_s = ST_LDSTALL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_LDSTALL: begin
                state_nxt_s = ST_RUN;
            end
            ST_BRFLUSH: begin
                if (cnt_r <= 2'd1) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = 2'd0;
                end else begin
                    cnt_nxt_s   = cnt_r - 2'd1;
                end
            end
            default: begin
                state_nxt_s = ST_RUN;
                cnt_nxt_s   = 2'd0;
            end
        endcase
    end

    // FSM outputs: Mealy stall/flush in the detection cycle, flush held through BRFLUSH.
    always_comb begin
        stall_s      = 1'b0;
        flush_ifid_s = 1'b0;
        flush_idex_s = 1'b0;
        if (rst) begin
            stall_s = 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (taken_s) begin
                        flush_ifid_s = 1'b1;
                        flush_idex_s = 1'b1;
                    end else if (load_use_s) begin
                        stall_s      = 1'b1;
                        flush_idex_s = 1'b1;
                    end else begin
                        stall_s      = 1'b0;
                    end
                end
                ST_BRFLUSH: begin
                    flush_ifid_s = 1'b1;
                    flush_idex_s = 1'b1;
                end
                default: begin
                    stall_s = 1'b0;
                end
            endcase
        end
    end

    // ID/Ex shadow: capture ID source fields, or insert an all-zero bubble on flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_rs_r     <= 5'd0;
            ex_rt_r     <= 5'd0;
            ex_rsuse_r  <= 1'b0;
            ex_rtuse_r  <= 1'b0;
            ex_alusrc_r <= 1'b0;
            ex_valid_r  <= 1'b0;
        end else if (flush_idex_s) begin
            ex_rs_r     <= 5'd0;
            ex_rt_r     <= 5'd0;
            ex_rsuse_r  <= 1'b0;
            ex_rtuse_r  <= 1'b0;
            ex_alusrc_r <= 1'b0;
            ex_valid_r  <= 1'b0;
        end else begin
            ex_rs_r     <= hz.Rs_Id;
            ex_rt_r     <= hz.Rt_Id;
            ex_rsuse_r  <= hz.RsUse_Id;
            ex_rtuse_r  <= hz.RtUse_Id;
            ex_alusrc_r <= hz.ALUSrc_Id;
            ex_valid_r  <= 1'b1;
        end
    end

    // Ex/Mem and Mem/Wr destination shadows advance every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            em_dst_r <= 5'd0;
            em_wr_r  <= 1'b0;
            em_ld_r  <= 1'b0;
            mw_dst_r <= 5'd0;
            mw_wr_r  <= 1'b0;
        end else begin
            em_dst_r <= hz.Reg_Target_Ex;
            em_wr_r  <= hz.RegWr_Ex & ex_valid_r;
            em_ld_r  <= hz.MemToReg_Ex;
            mw_dst_r <= em_dst_r;
            mw_wr_r  <= em_wr_r;
        end
    end

    // Bypass selects for the instruction currently in Ex; immediate overrides ALU B only.
    always_comb begin
        rs_fwd_s = fwd_sel(ex_rs_r, ex_rsuse_r, em_dst_r, em_wr_r, em_ld_r, mw_dst_r, mw_wr_r);
        rt_fwd_s = fwd_sel(ex_rt_r, ex_rtuse_r, em_dst_r, em_wr_r, em_ld_r, mw_dst_r, mw_wr_r);
        if (ex_alusrc_r) begin
            srcb_s = 2'b10;
        end else begin
            srcb_s = rt_fwd_s;
        end
    end

    assign hz.ALUSrcA_ByPassing = rs_fwd_s;
    assign hz.ALUSrcB_ByPassing = srcb_s;
    assign hz.busBSrc_ByPassing = rt_fwd_s;
    assign hz.Stall_PC          = stall_s;
    assign hz.Stall_IfId        = stall_s;
    assign hz.Flush_IfId        = flush_ifid_s;
    assign hz.Flush_IdEx        = flush_idex_s;

`ifdef HAZ_PERF_CNT_EN
    // Saturating counts of stall cycles and IF/ID flush cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Stall_Cnt <= '0;
            Flush_Cnt <= '0;
        end else begin
            if (stall_s && (Stall_Cnt != {CNT_W{1'b1}})) begin
                Stall_Cnt <= Stall_Cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                Stall_Cnt <= Stall_Cnt;
            end
            if (flush_ifid_s && (Flush_Cnt != {CNT_W{1'b1}})) begin
                Flush_Cnt <= Flush_Cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                Flush_Cnt <= Flush_Cnt;
            end
        end
    end
`endif

endmodule
